// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiply / restoring divide for the M-extension ops.
// Define MULDIV_FAST_MUL_EN to route multiplies through a single-cycle multiplier.
module muldiv_sequencer #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   alu_control,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         kill,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result
);
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;
  localparam int CW = $clog2(n) + 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;
  state_t r_state, w_next;
  logic [2*n-1:0] r_p;
  logic [n-1:0]   r_m, r_result;
  logic [CW-1:0]  r_cnt;
  logic           r_neg, r_hi;
  logic           w_is_mul, w_is_div, w_rem, w_sa, w_sb, w_hi_sel, w_neg;
  logic           w_dz, w_ovf, w_special, w_fast, w_imm_go, w_accept, w_iter, w_last;
  logic [n-1:0]   w_ma, w_mb, w_imm, w_diff, w_dsel, w_dres, w_mres;
  logic [2*n-1:0] w_prod, w_fp, w_mul_p, w_div_p, w_mneg;
  logic [n:0]     w_sum, w_sh;
  logic           w_ge;
  assign w_is_mul = alu_control inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  assign w_is_div = alu_control inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign w_rem    = alu_control inside {ALU_REM, ALU_REMU};
  assign w_sa     = A[n-1] & (alu_control inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
  assign w_sb     = B[n-1] & (alu_control inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM});
  assign w_ma     = w_sa ? -A : A;
  assign w_mb     = w_sb ? -B : B;
  assign w_hi_sel = alu_control inside {ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_REM, ALU_REMU};
  assign w_neg    = w_rem ? w_sa : w_sa ^ w_sb;
  assign w_dz     = w_is_div & (B == '0);
  assign w_ovf    = (alu_control inside {ALU_DIV, ALU_REM}) & (A == {1'b1, {(n-1){1'b0}}}) & (&B);
  assign w_special = (!w_is_mul & !w_is_div) | w_dz | w_ovf;
`ifdef MULDIV_FAST_MUL_EN
  assign w_fast = 1'b1;
  assign w_prod = {{n{1'b0}}, w_ma} * {{n{1'b0}}, w_mb};
`else
  assign w_fast = 1'b0;
  assign w_prod = '0;
`endif
  assign w_fp     = w_neg ? -w_prod : w_prod;
  assign w_imm_go = w_special | (w_fast & w_is_mul);
  assign w_imm    = w_dz ? (w_rem ? A : '1) :
                    w_ovf ? (w_rem ? '0 : A) :
                    w_is_mul ? (w_hi_sel ? w_fp[2*n-1:n] : w_fp[n-1:0]) : '0;
  // one shift-add step: add multiplicand into the high half, then shift the pair right
  assign w_sum   = {1'b0, r_p[2*n-1:n]} + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_mul_p = {w_sum, r_p[n-1:1]};
  // one restoring step: shift {rem,quot} left, keep the trial difference if it did not borrow
  assign w_sh    = r_p[2*n-1:n-1];
  assign w_ge    = w_sh >= {1'b0, r_m};
  assign w_diff  = w_sh[n-1:0] - r_m;
  assign w_div_p = {w_ge ? w_diff : w_sh[n-1:0], r_p[n-2:0], w_ge};
  assign w_mneg  = r_neg ? -w_mul_p : w_mul_p;
  assign w_mres  = r_hi ? w_mneg[2*n-1:n] : w_mneg[n-1:0];
  assign w_dsel  = r_hi ? w_div_p[2*n-1:n] : w_div_p[n-1:0];
  assign w_dres  = r_neg ? -w_dsel : w_dsel;
  assign w_last   = r_cnt == LAST;
  assign w_accept = (r_state == S_IDLE) & start & !kill;
  assign w_iter   = ((r_state == S_MUL) | (r_state == S_DIV)) & !kill;
  always_comb begin
    w_next = r_state;
    if (kill) w_next = S_IDLE;
    else
      case (r_state)
        S_IDLE:  if (start) w_next = w_imm_go ? S_FIN : (w_is_mul ? S_MUL : S_DIV);
        S_MUL,
        S_DIV:   if (w_last) w_next = S_FIN;
        default: w_next = S_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_p      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_hi     <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_p   <= {{n{1'b0}}, w_is_mul ? w_mb : w_ma};
        r_m   <= w_is_mul ? w_ma : w_mb;
        r_neg <= w_neg;
        r_hi  <= w_hi_sel;
        r_cnt <= '0;
        if (w_imm_go) r_result <= w_imm;
      end else if (w_iter) begin
        r_p   <= (r_state == S_DIV) ? w_div_p : w_mul_p;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_result <= (r_state == S_DIV) ? w_dres : w_mres;
      end
    end
  end
  assign busy   = r_state != S_IDLE;
  assign done   = r_state == S_FIN;
  assign result = r_result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of muldiv_sequencer latency, results, kill and reset.
module tb_muldiv_sequencer;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;
`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
  localparam int HELD_DONES = 20;
`else
  localparam int ML = 33;
  localparam int HELD_DONES = 1;
`endif
  logic        clk, rst, start, kill, busy, done;
  logic [4:0]  alu_control;
  logic [31:0] A, B, result;
  int n_pass = 0;
  int n_total = 0;

  muldiv_sequencer #(.n(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
    .A(A), .B(B), .kill(kill), .busy(busy), .done(done), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int c;
    alu_control = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    while (done !== 1'b1 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    chk({tag, "_lat"}, c, lat);
    chk({tag, "_res"}, result, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int d, first;
    rst = 1'b0; start = 1'b0; kill = 1'b0; alu_control = '0; A = '0; B = '0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_op("div_neg",  ALU_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    do_op("rem_neg",  ALU_REM,  32'd7, 32'hFFFFFFFE, 32'h00000001, 33);
    do_op("divu_dz",  ALU_DIVU, 32'h1234, 32'd0, 32'hFFFFFFFF, 1);
    do_op("remu_dz",  ALU_REMU, 32'h1234, 32'd0, 32'h00001234, 1);
    do_op("div_ovf",  ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("rem_ovf",  ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    do_op("mulh",     ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, ML);
    do_op("mulhsu",   ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, ML);
    do_op("mulhu",    ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML);
    do_op("mul",      ALU_MUL,    32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, ML);
    alu_control = ALU_DIVU; A = 32'd1000; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d = 0;
    for (int i = 1; i < 10; i++) begin
      d += int'(done);
      @(posedge clk); #1;
    end
    kill = 1'b1;
    d += int'(done);
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_no_done_before", d, 0);
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_done", {31'b0, done}, 32'd0);
    chk("kill_result_held", result, 32'hFFFFFFFD);
    do_op("divu_after_kill", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);
    do_op("bad_op", 5'd0, 32'd5, 32'd6, 32'd0, 1);
    alu_control = ALU_MUL; A = 32'd5; B = 32'd6; start = 1'b1;
    d = 0; first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        d++;
        if (first == 0) first = i;
      end
      if (i == ML + 1) chk("held_idle_after_done", {31'b0, busy}, 32'd0);
      if (i == ML + 2) chk("held_second_accept", {31'b0, busy}, 32'd1);
    end
    start = 1'b0;
    chk("held_done_count", d, HELD_DONES);
    chk("held_first_done", first, ML);
    chk("held_result", result, 32'd30);
    for (int i = 0; i < 40 && busy === 1'b1; i++) begin
      @(posedge clk); #1;
    end
    alu_control = ALU_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_done", {31'b0, done}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller for the M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It replaces the single-cycle combinational multiply, divide and remainder paths in the ALU with an iterative shift-add / restoring-divide engine. It sits beside ALU_nbit in the execute stage: the pipeline control stalls on `busy` and writes back `result` when `done` pulses.

## Interface
- `n`, 32, operand and result width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `alu_control`  in  5  operation code, same `ALU_*` encoding from defines.v used by the ALU.
- `A`  in  n  rs1 operand; captured on the edge where start is accepted.
- `B`  in  n  rs2 operand; captured on the same edge.
- `kill`  in  1  pipeline flush; aborts any operation in progress.
- `busy`  out  1  high from the cycle after acceptance until the cycle done is high, inclusive.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  n  final value; held until the next accepted start.

## Operation
- Reset: state IDLE, `busy`=0, `done`=0, `result`=0, and all internal registers are cleared.
- States:
  - IDLE: start=1 captures the op and operands. Special cases and fast mul go to FIN; mul ops go to MUL; div/rem ops go to DIV.
  - MUL: n iterations. Each one adds the multiplicand if the multiplier LSB is 1, then shifts, giving a 2n-bit unsigned product.
  - DIV: n restoring iterations: shift, trial-subtract the divisor, keep or restore. This yields the quotient and remainder.
  - FIN: applies sign correction, registers `result` and asserts `done`, then returns to IDLE.
- Sign handling:
  - Operands are converted to magnitudes at capture.
  - MUL/MULH: A and B are signed. MULHSU: A is signed, B is unsigned. MULHU/DIVU/REMU: both unsigned.
  - Product sign is sign(A) XOR sign(B), restricted to the signed operands.
  - Quotient sign is sign(A) XOR sign(B). Remainder takes sign(A).
- Result selection:
  - MUL returns product[n-1:0].
  - MULH, MULHSU and MULHU return product[2n-1:n], taken after 2n-bit negation when the product is negative.
- Special cases are detected at capture, skip iteration and go IDLE→FIN:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
  - Unrecognised op: result 0.
- An iteration counter (log2(n)+1 bits) counts 0..n-1. The last iteration transitions to FIN.
- `start` while busy is ignored. No queueing.
- `kill` has priority over everything, including start in IDLE and the FIN transition:
  - Next edge: state IDLE, `busy`=0, no `done`.
  - `result` keeps its previous value.
- `rst` asserted at any time forces the reset state immediately, independent of clk.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- Iterative ops: `busy`=1 in cycles 1..n+1. `done`=1 in cycle n+1 (cycle 33 for n=32), and `result` updates at the same edge.
- Special-case and fast-path ops: `busy`=1 and `done`=1 in cycle 1.
- The earliest next start is accepted in the cycle after done; there is no back-to-back overlap.
- `result` is registered; there is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MUL, MULH, MULHSU and MULHU use a single-cycle 2n-bit multiplier and go IDLE→FIN, with done in cycle 1. Divide ops are unchanged.
- `MULDIV_FAST_MUL_EN` undefined: all multiplies iterate through MUL, with done in cycle n+1. The iterative path uses no hardware multiplier.

## Test plan
- DIV A=7, B=0xFFFFFFFE (-2) → result 0xFFFFFFFD (-3) with done in cycle 33. The REM of the same operands → 0x00000001.
- DIVU A=0x1234, B=0 → result 0xFFFFFFFF with done in cycle 1. REMU of the same operands → 0x00001234.
- DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000 in cycle 1. REM of the same operands → 0x00000000.
- Multiply cases, checked with the macro both on and off (done in cycle 1 vs 33):
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MUL 0xFFFFFFFF × 3 → 0xFFFFFFFD.
- kill in cycle 10 of a DIVU → busy=0 in cycle 11, no done, result unchanged. A start in cycle 11 with DIVU 100/7 → done in cycle 44 (cycle 33 of the new op), result 14.
- start held high for 40 cycles with a MUL 5×6 → exactly one done pulse (cycle 33), result 30, and a second op accepted in cycle 34. rst dropped mid-operation → all outputs 0 asynchronously.
